acc_cpu_ctrl: RTL and testbench
===============================

Name: acc_cpu_ctrl

Overview:
- Accumulator-style fetch/execute controller on the requester side of the 32x8 program/data RAM.
- Drives RAM address, write-enable, write data and the Initialize strobe; consumes registered RAM read data.
- Executes 8-bit instructions stored in the RAM.
- Sits between top-level Start/status I/O and the RAM.

Parameters:
- AW, 5, RAM address width; the PC wraps at 2^AW.
- DW, 8, data/instruction width.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level-sampled; starts a run from IDLE or HALT.
- Initialize  out  1  one-cycle strobe that loads the RAM boot image.
- WE  out  1  RAM write enable.
- addr  out  AW  RAM address.
- ram_wdata  out  DW  to RAM data_IN.
- ram_rdata  in  DW  from RAM data_Out; valid the cycle after the read address is presented with WE=0.
- Acc  out  DW  accumulator.
- PC  out  AW  program counter.
- Zflag  out  1  zero flag.
- Cflag  out  1  carry/borrow flag.
- Halted  out  1  high while in HALT.
- Busy  out  1  high in every state except IDLE and HALT.

Behaviour:
- Reset (Reset=0, async): state=IDLE, Acc=0, PC=0, IR=0, Zflag=0, Cflag=0. Outputs are zero: WE=0, Initialize=0, addr=0, ram_wdata=0, Halted=0, Busy=0.
- Instruction format: opcode=IR[7:5], operand a=IR[4:0].
  - 000 LDA: A<=M[a]
  - 001 STA: M[a]<=A
  - 010 ADD: A<=A+M[a]
  - 011 SUB: A<=A-M[a]
  - 100 JMP: PC<=a
  - 101 JZ: jump if Z
  - 110 JC: jump if C
  - 111 HLT
- Arithmetic is 8-bit modulo.
  - ADD: C=carry-out of the 9-bit sum.
  - SUB: C=1 iff A<M[a] (unsigned borrow).
  - LDA/ADD/SUB set Z=(result==0).
  - LDA clears C.
  - Other instructions leave flags unchanged.
- RAM outputs are combinational from state and registers. WE=1 only in STORE. Initialize=1 only in INIT. In all other states addr=PC, except READ/STORE where addr=a.
- FSM:
  - IDLE: Start=1 -> INIT.
  - INIT: Initialize=1 for exactly one cycle; clear PC, Acc and flags -> FETCH.
  - FETCH: addr=PC, WE=0 -> DECODE.
  - DECODE: IR<=ram_rdata, PC<=PC+1 (wraps 31->0). Next state by opcode:
    - LDA/ADD/SUB -> READ.
    - STA -> STORE.
    - JMP -> FETCH with PC<=a; this overrides the increment.
    - JZ/JC -> FETCH with PC<=a if the flag is set, else PC+1.
    - HLT -> HALT.
  - READ: addr=a, WE=0 -> EXEC.
  - EXEC: operate on ram_rdata -> FETCH.
  - STORE: addr=a, WE=1, ram_wdata=Acc -> FETCH.
  - HALT: Halted=1; PC points past the HLT. Start=1 -> INIT (full restart); Start=0 -> stay.
- Cycle counts (FETCH to next FETCH):
  - LDA/ADD/SUB: 4
  - STA: 3
  - JMP/JZ/JC: 2
- Start is ignored outside IDLE and HALT.
- Reset mid-instruction aborts immediately. No RAM write completes after Reset falls, because WE drops asynchronously.
- Self-modifying code is legal: STA followed by FETCH of the same address returns the new value.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port Step (1 bit).
  - The FSM holds in FETCH, with addr=PC and Busy=1, until Step=1 is sampled. It then advances to DECODE as normal.
  - One instruction executes per Step-high cycle seen in FETCH.
  - Step is ignored in every other state.
- Undefined: the port is absent and FETCH always advances after one cycle.

Test Plan:
- All tests use a bench RAM model with the same timing: 1-cycle registered read, write at the clock edge when WE=1.
- Test 1: preload M[0]=LDA 20 (0x14), M[1]=ADD 21 (0x55), M[2]=STA 22 (0x36), M[3]=HLT (0xE0), M[20]=0x05, M[21]=0x07; pulse Start -> Initialize high exactly 1 cycle; M[22]=0x0C; Acc=0x0C; Z=0; C=0; Halted after 4+4+3+2 cycles post-INIT; PC=4.
- Test 2: M[20]=0xF0, M[21]=0x20; LDA 20, ADD 21, HLT -> Acc=0x10, C=1, Z=0.
- Test 3: M[20]=0x03, M[21]=0x03; LDA 20, SUB 21, JZ 7, HLT at 3, HLT at 7 -> Z=1; final PC=8; WE never asserted. Repeat with M[21]=0x04 -> Acc=0xFF, C=1, Z=0, halts with PC=4.
- Test 4: M[31]=JMP 31 (0x9F); M[0]=JMP 31 -> PC sequence 31, 31, ... with no halt. Separately, a non-jump at 31 wraps PC to 0.
- Test 5: pull Reset low during the STORE cycle of STA -> WE=0 immediately; target cell unchanged; all outputs at reset values; Start afterwards re-runs the program from PC=0.
- Test 6 (SINGLE_STEP_EN): program from Test 1, Step held 0 -> stays in FETCH with PC=0 indefinitely. Each 1-cycle Step pulse completes exactly one instruction: PC 0→1→2→3.

Source files
------------

// File: rtl/acc_cpu_ctrl_if.sv
// RAM-side bus of the accumulator CPU controller.
// The controller drives the address, write enable, write data and the
// Initialize (boot image load) strobe; the RAM returns registered read data.
interface acc_cpu_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          Initialize;
  logic          WE;
  logic [AW-1:0] addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport master (
    output Initialize,
    output WE,
    output addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  Initialize,
    input  WE,
    input  addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/acc_cpu_ctrl.sv
// Accumulator-style fetch/execute controller for a 32x8 program/data RAM.
// Instructions: opcode = IR[7:5], operand a = IR[4:0].
//   000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JZ, 110 JC, 111 HLT.
// RAM outputs are decoded straight from the state register, so a falling
// Reset removes WE in the same cycle and no write can complete.
// Optional build macro SINGLE_STEP_EN: adds input Step; FETCH then waits for
// Step=1 before decoding, so one instruction runs per Step pulse.
module acc_cpu_ctrl #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
`ifdef SINGLE_STEP_EN
  input  logic          Step,
`endif
  acc_cpu_ctrl_if.master ram,
  output logic [DW-1:0] Acc,
  output logic [AW-1:0] PC,
  output logic          Zflag,
  output logic          Cflag,
  output logic          Halted,
  output logic          Busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_READ   = 3'd4,
    S_EXEC   = 3'd5,
    S_STORE  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_JC  = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  state_t        state_r, state_s;
  logic [DW-1:0] acc_r, acc_s;
  logic [AW-1:0] pc_r, pc_s;
  logic [DW-1:0] ir_r, ir_s;
  logic          z_r, z_s;
  logic          c_r, c_s;

  logic [AW-1:0] pc_inc_s;
  logic [AW-1:0] operand_s;
  logic [AW-1:0] fetch_target_s;
  opcode_t       fetch_op_s;
  opcode_t       exec_op_s;
  logic [DW:0]   sum_s;
  logic [DW:0]   diff_s;
  logic          step_go_s;

  assign pc_inc_s       = pc_r + {{(AW-1){1'b0}}, 1'b1};
  assign operand_s      = ir_r[AW-1:0];
  assign fetch_target_s = ram.ram_rdata[AW-1:0];
  assign fetch_op_s     = opcode_t'(ram.ram_rdata[DW-1:DW-3]);
  assign exec_op_s      = opcode_t'(ir_r[DW-1:DW-3]);
  // Borrow of the 9-bit difference is exactly the unsigned A < M condition.
  assign sum_s          = {1'b0, acc_r} + {1'b0, ram.ram_rdata};
  assign diff_s         = {1'b0, acc_r} - {1'b0, ram.ram_rdata};

`ifdef SINGLE_STEP_EN
  assign step_go_s = Step;
`else
  assign step_go_s = 1'b1;
`endif

  // State and datapath registers; asynchronous reset aborts any instruction.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IDLE;
      acc_r   <= '0;
      pc_r    <= '0;
      ir_r    <= '0;
      z_r     <= 1'b0;
      c_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      pc_r    <= pc_s;
      ir_r    <= ir_s;
      z_r     <= z_s;
      c_r     <= c_s;
    end
  end

  // Next-state and datapath update logic; everything holds unless a state changes it.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    pc_s    = pc_r;
    ir_s    = ir_r;
    z_s     = z_r;
    c_s     = c_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          state_s = S_INIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT: begin
        pc_s    = '0;
        acc_s   = '0;
        z_s     = 1'b0;
        c_s     = 1'b0;
        state_s = S_FETCH;
      end
      S_FETCH: begin
        if (step_go_s) begin
          state_s = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Opcode comes straight from the RAM data; IR is only loaded this edge.
        ir_s = ram.ram_rdata;
        pc_s = pc_inc_s;
        case (fetch_op_s)
          OP_LDA, OP_ADD, OP_SUB: state_s = S_READ;
          OP_STA:                 state_s = S_STORE;
          OP_JMP: begin
            pc_s    = fetch_target_s;
            state_s = S_FETCH;
          end
          OP_JZ: begin
            if (z_r) begin
              pc_s = fetch_target_s;
            end else begin
              pc_s = pc_inc_s;
            end
            state_s = S_FETCH;
          end
          OP_JC: begin
            if (c_r) begin
              pc_s = fetch_target_s;
            end else begin
              pc_s = pc_inc_s;
            end
            state_s = S_FETCH;
          end
          OP_HLT:  state_s = S_HALT;
          default: state_s = S_IDLE;
        endcase
      end
      S_READ: begin
        state_s = S_EXEC;
      end
      S_EXEC: begin
        case (exec_op_s)
          OP_LDA: begin
            acc_s = ram.ram_rdata;
            z_s   = (ram.ram_rdata == {DW{1'b0}});
            c_s   = 1'b0;
          end
          OP_ADD: begin
            acc_s = sum_s[DW-1:0];
            z_s   = (sum_s[DW-1:0] == {DW{1'b0}});
            c_s   = sum_s[DW];
          end
          OP_SUB: begin
            acc_s = diff_s[DW-1:0];
            z_s   = (diff_s[DW-1:0] == {DW{1'b0}});
            c_s   = diff_s[DW];
          end
          default: begin
            acc_s = acc_r;
          end
        endcase
        state_s = S_FETCH;
      end
      S_STORE: begin
        state_s = S_FETCH;
      end
      S_HALT: begin
        if (Start) begin
          state_s = S_INIT;
        end else begin
          state_s = S_HALT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // RAM bus and status decode from the state register.
  always_comb begin
    ram.Initialize = (state_r == S_INIT);
    ram.WE         = (state_r == S_STORE);
    if ((state_r == S_READ) || (state_r == S_STORE)) begin
      ram.addr = operand_s;
    end else begin
      ram.addr = pc_r;
    end
    if (state_r == S_STORE) begin
      ram.ram_wdata = acc_r;
    end else begin
      ram.ram_wdata = '0;
    end
    Halted = (state_r == S_HALT);
    Busy   = (state_r != S_IDLE) && (state_r != S_HALT);
  end

  assign Acc   = acc_r;
  assign PC    = pc_r;
  assign Zflag = z_r;
  assign Cflag = c_r;

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Self-checking bench for acc_cpu_ctrl: a RAM model with 1-cycle registered
// read loads a boot image on Initialize. Each program run pushes its expected
// final state into a scoreboard queue; a monitor pops and compares when the
// DUT raises Halted.
module tb_acc_cpu_ctrl;

  typedef struct {
    int         tid;
    logic [7:0] acc;
    logic [4:0] pc;
    logic       z;
    logic       c;
    int         cycles;
    logic       we;
    logic       chk_mem;
    logic [4:0] maddr;
    logic [7:0] mdata;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
`ifdef SINGLE_STEP_EN
  logic Step = 1'b0;
`endif
  logic [7:0] Acc;
  logic [4:0] PC;
  logic       Zflag, Cflag, Halted, Busy;

  acc_cpu_ctrl_if #(.AW(5), .DW(8)) bus ();

  acc_cpu_ctrl #(.AW(5), .DW(8)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
`ifdef SINGLE_STEP_EN
    .Step   (Step),
`endif
    .ram    (bus),
    .Acc    (Acc),
    .PC     (PC),
    .Zflag  (Zflag),
    .Cflag  (Cflag),
    .Halted (Halted),
    .Busy   (Busy)
  );

  always #5 Clock = ~Clock;

  logic [7:0] boot [32];
  logic [7:0] mem  [32];

  // RAM model: boot load on Initialize, write on WE, registered read.
  always @(posedge Clock) begin
    if (bus.Initialize) begin
      for (int i = 0; i < 32; i++) mem[i] <= boot[i];
    end else if (bus.WE) begin
      mem[bus.addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.addr];
  end

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int tid, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL t%0d %s actual=0x%0h expected=0x%0h", tid, nm, act, exp);
    end
  endtask

  // Monitor: Initialize width, WE activity, and scoreboard compare on Halted rise.
  initial begin
    int   init_w   = 0;
    int   cyc      = 0;
    logic we_seen  = 1'b0;
    logic halted_q = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clock);
      if (bus.Initialize) begin
        init_w++;
        cyc     = 0;
        we_seen = 1'b0;
      end else begin
        if (init_w != 0) begin
          chk("init_width", 0, init_w, 1);
          init_w = 0;
        end
        cyc++;
      end
      if (bus.WE) we_seen = 1'b1;
      if (Halted && !halted_q) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL t0 unexpected_halt actual=PC 0x%0h expected=no halt", PC);
        end else begin
          e = sb_q.pop_front();
          chk("acc",    e.tid, Acc,     e.acc);
          chk("pc",     e.tid, PC,      e.pc);
          chk("zflag",  e.tid, Zflag,   e.z);
          chk("cflag",  e.tid, Cflag,   e.c);
          chk("cycles", e.tid, cyc,     e.cycles);
          chk("we",     e.tid, we_seen, e.we);
          chk("busy",   e.tid, Busy,    1'b0);
          if (e.chk_mem) chk("mem", e.tid, mem[e.maddr], e.mdata);
        end
      end
      halted_q = Halted;
    end
  end

  task automatic clear_boot();
    for (int i = 0; i < 32; i++) boot[i] = 8'h00;
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic run_prog(input exp_t e);
    int n;
    sb_q.push_back(e);
    pulse_start();
    n = 0;
    while (!Halted && n < 300) begin
      @(negedge Clock);
      n++;
    end
    if (!Halted) begin
      n_total++;
      $display("FAIL t%0d halt_timeout actual=not halted expected=halted", e.tid);
      void'(sb_q.pop_back());
    end
    @(negedge Clock);
  endtask

  task automatic chk_reset_outputs(input int tid);
    chk("rst_we",    tid, bus.WE,         1'b0);
    chk("rst_init",  tid, bus.Initialize, 1'b0);
    chk("rst_addr",  tid, bus.addr,       5'd0);
    chk("rst_wdata", tid, bus.ram_wdata,  8'h00);
    chk("rst_acc",   tid, Acc,            8'h00);
    chk("rst_pc",    tid, PC,             5'd0);
    chk("rst_flags", tid, {Zflag, Cflag}, 2'b00);
    chk("rst_stat",  tid, {Halted, Busy}, 2'b00);
  endtask

  task automatic load_t1();
    clear_boot();
    boot[0]  = 8'h14;  // LDA 20
    boot[1]  = 8'h55;  // ADD 21
    boot[2]  = 8'h36;  // STA 22
    boot[3]  = 8'hE0;  // HLT
    boot[20] = 8'h05;
    boot[21] = 8'h07;
  endtask

  initial begin
    exp_t e;
    int   n;
    clear_boot();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    #12;
    chk_reset_outputs(0);
    @(negedge Clock);
    Reset = 1'b1;

    // Test 1: LDA/ADD/STA/HLT, 1 + 4 + 4 + 3 + 2 cycles from INIT to HALT.
    load_t1();
    e = '{tid:1, acc:8'h0C, pc:5'd4, z:1'b0, c:1'b0, cycles:14, we:1'b1,
          chk_mem:1'b1, maddr:5'd22, mdata:8'h0C};
    run_prog(e);

    // Test 2: ADD with carry out, restarted from HALT.
    clear_boot();
    boot[0] = 8'h14; boot[1] = 8'h55; boot[2] = 8'hE0;
    boot[20] = 8'hF0; boot[21] = 8'h20;
    e = '{tid:2, acc:8'h10, pc:5'd3, z:1'b0, c:1'b1, cycles:11, we:1'b0,
          chk_mem:1'b0, maddr:5'd0, mdata:8'h00};
    run_prog(e);

    // Test 3a: SUB to zero, JZ taken to the HLT at 7.
    clear_boot();
    boot[0] = 8'h14; boot[1] = 8'h75; boot[2] = 8'hA7; boot[3] = 8'hE0; boot[7] = 8'hE0;
    boot[20] = 8'h03; boot[21] = 8'h03;
    e = '{tid:3, acc:8'h00, pc:5'd8, z:1'b1, c:1'b0, cycles:13, we:1'b0,
          chk_mem:1'b0, maddr:5'd0, mdata:8'h00};
    run_prog(e);

    // Test 3b: SUB with borrow, JZ not taken, HLT at 3.
    boot[21] = 8'h04;
    e = '{tid:4, acc:8'hFF, pc:5'd4, z:1'b0, c:1'b1, cycles:13, we:1'b0,
          chk_mem:1'b0, maddr:5'd0, mdata:8'h00};
    run_prog(e);

    // Test 4a: JMP 31 at 0 and at 31 loops forever at PC=31.
    clear_boot();
    boot[0] = 8'h9F; boot[31] = 8'h9F;
    pulse_start();
    repeat (4) @(negedge Clock);
    for (int k = 0; k < 4; k++) begin
      repeat (5) @(negedge Clock);
      chk("loop_pc",   5, PC,     5'd31);
      chk("loop_halt", 5, Halted, 1'b0);
    end
    Reset = 1'b0;
    #1;
    chk_reset_outputs(5);
    @(negedge Clock);
    Reset = 1'b1;

    // Test 4b: LDA at 31 wraps PC to 0; JZ then reaches the HLT at 5.
    clear_boot();
    boot[0] = 8'hA5; boot[1] = 8'h9F; boot[5] = 8'hE0; boot[31] = 8'h1E; boot[30] = 8'h00;
    e = '{tid:6, acc:8'h00, pc:5'd6, z:1'b1, c:1'b0, cycles:13, we:1'b0,
          chk_mem:1'b0, maddr:5'd0, mdata:8'h00};
    run_prog(e);

    // Test 5: Reset during STORE drops WE at once; cell 22 keeps its boot value.
    load_t1();
    pulse_start();
    n = 0;
    while (!bus.WE && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("store_reached", 7, bus.WE, 1'b1);
    Reset = 1'b0;
    #1;
    chk_reset_outputs(7);
    repeat (2) @(negedge Clock);
    chk("mem_kept", 7, mem[22], 8'h00);
    Reset = 1'b1;
    e = '{tid:8, acc:8'h0C, pc:5'd4, z:1'b0, c:1'b0, cycles:14, we:1'b1,
          chk_mem:1'b1, maddr:5'd22, mdata:8'h0C};
    run_prog(e);

`ifdef SINGLE_STEP_EN
    // Test 6: FETCH waits for Step; one instruction per Step pulse.
    load_t1();
    pulse_start();
    repeat (20) @(negedge Clock);
    chk("step_hold_pc",   9, PC,       5'd0);
    chk("step_hold_busy", 9, Busy,     1'b1);
    chk("step_hold_addr", 9, bus.addr, 5'd0);
    for (int k = 1; k <= 3; k++) begin
      Step = 1'b1;
      @(negedge Clock);
      Step = 1'b0;
      repeat (8) @(negedge Clock);
      chk("step_pc", 9, PC, k);
      if (k == 2) chk("step_acc", 9, Acc, 8'h0C);
      if (k == 3) chk("step_mem", 9, mem[22], 8'h0C);
    end
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
`endif

    repeat (2) @(negedge Clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
